row_scan_encoder: RTL

- Inverse of the 5-to-32 row decoder: takes a 32-bit row-request vector and emits the 5-bit row address of every set bit, one address per handshake.
- Sits between the row-request logic and the row-address bus that feeds the decoder.
- When each emitted address is fed back through the row decoder, it must reproduce exactly one of the requested rows.
- Sequential: snapshots the vector, then serialises the set rows in priority order under valid/ready flow control.

---
 rtl/row_pkg.sv | 20 ++
 rtl/prio_enc32.sv | 26 ++
 rtl/row_scan_encoder.sv | 104 ++++++++++
 3 files changed

// File: rtl/row_pkg.sv
// Shared constants, FSM state type and address-to-one-hot helper for the row scan encoder.
package row_pkg;

    localparam int N_ROWS = 32;
    localparam int ADDR_W = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Decoder model: a row address expands to the single row it selects.
    function automatic logic [N_ROWS-1:0] addr_to_onehot(input logic [ADDR_W-1:0] addr);
        logic [N_ROWS-1:0] oh;
        oh       = {N_ROWS{1'b0}};
        oh[addr] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/prio_enc32.sv
// 32-to-5 priority encoder; lsb_first selects whether the lowest or highest set bit wins.
module prio_enc32
    import row_pkg::*;
(
    input  logic [N_ROWS-1:0] vec,
    input  logic              lsb_first,
    output logic [ADDR_W-1:0] idx,
    output logic              found
);

    // Scan so the winning bit is the last one written.
    always_comb begin
        idx   = {ADDR_W{1'b0}};
        found = |vec;
        if (lsb_first) begin
            for (int i = N_ROWS - 1; i >= 0; i--) begin
                idx = vec[i] ? ADDR_W'(i) : idx;
            end
        end else begin
            for (int i = 0; i < N_ROWS; i++) begin
                idx = vec[i] ? ADDR_W'(i) : idx;
            end
        end
    end

endmodule

// File: rtl/row_scan_encoder.sv
// Snapshots a 32-bit row-request vector and serialises the address of each set row
// under valid/ready flow control; outputs come only from registered state.
module row_scan_encoder
    import row_pkg::*;
#(
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_ROWS-1:0] in_rows,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [ADDR_W:0]   out_count,
    output logic              empty_err
);

    state_t              state_r;
    state_t              state_nxt_s;
    logic [N_ROWS-1:0]   pending_r;
    logic [N_ROWS-1:0]   pending_nxt_s;
    logic                empty_err_r;
    logic                empty_err_nxt_s;
    logic [ADDR_W-1:0]   enc_idx_s;
    logic                enc_found_s;
    logic [ADDR_W:0]     count_s;

    prio_enc32 u_prio (
        .vec       (pending_r),
        .lsb_first (LSB_FIRST),
        .idx       (enc_idx_s),
        .found     (enc_found_s)
    );

    // Population count of the rows still pending.
    always_comb begin
        count_s = {(ADDR_W + 1){1'b0}};
        for (int i = 0; i < N_ROWS; i++) begin
            count_s = count_s + {{ADDR_W{1'b0}}, pending_r[i]};
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == SCAN);
    assign out_addr  = enc_found_s ? enc_idx_s : {ADDR_W{1'b0}};
    assign out_count = count_s;
    assign out_last  = out_valid && (count_s == 6'd1);
    assign empty_err = empty_err_r;

    // Next-state, snapshot and error-pulse logic.
    always_comb begin
        state_nxt_s     = state_r;
        pending_nxt_s   = pending_r;
        empty_err_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    if (in_rows == 32'd0) begin
                        empty_err_nxt_s = 1'b1;
                    end else begin
                        pending_nxt_s = in_rows;
                        state_nxt_s   = SCAN;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SCAN: begin
                if (out_ready) begin
                    // Retire exactly the row just presented.
                    pending_nxt_s = pending_r & ~addr_to_onehot(enc_idx_s);
                    if (out_last) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = SCAN;
                    end
                end else begin
                    state_nxt_s = SCAN;
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                pending_nxt_s = 32'd0;
            end
        endcase
    end

    // State, snapshot and error-pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            pending_r   <= 32'd0;
            empty_err_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            pending_r   <= pending_nxt_s;
            empty_err_r <= empty_err_nxt_s;
        end
    end

endmodule
